// File: rtl/mtime_access_ctrl.sv
// Machine-timer access controller.
// Round-robin arbitration of 64-bit requests onto the 32-bit mtime/mtimecmp
// register port. Reads use hi-lo-hi with bounded retry so a carry between the
// two halves is never returned. Writes use guard-lo, hi, lo so no intermediate
// value can raise a spurious timer interrupt.
module mtime_access_ctrl #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ-1:0]     req_reg,
    input  logic [NUM_REQ*64-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [63:0]            resp_rdata,
    output logic                   resp_err,
    output logic                   mt_rd_en,
    output logic                   mt_wr_en,
    output logic [1:0]             mt_addr,
    output logic [31:0]            mt_wr_data,
    output logic [3:0]             mt_wr_strobe,
    input  logic [31:0]            mt_rd_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_HI1, S_RD_LO, S_RD_HI2, S_WR_GUARD, S_WR_HI, S_WR_LO, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          we_q, we_d;
    logic          reg_q, reg_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cidx;
    int            cand;
    logic [63:0]   gnt_wdata;

    // Round-robin pick: scan from the farthest candidate down so the one
    // closest to rr_ptr is written last and wins.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cidx      = '0;
        gnt_wdata = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cidx = IW'(cand);
            if (req_valid[cidx]) begin
                gnt_vld = 1'b1;
                gnt_idx = cidx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == gnt_idx) gnt_wdata = req_wdata[64*i +: 64];
        end
    end

    // Requester-side handshake and completion pulse.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == S_IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
        if (state_q == S_RESP) resp_valid[owner_q] = 1'b1;
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Timer port drive, purely from state and the latched request.
    always_comb begin
        mt_rd_en     = 1'b0;
        mt_wr_en     = 1'b0;
        mt_addr      = 2'b00;
        mt_wr_data   = 32'h0;
        mt_wr_strobe = 4'h0;
        case (state_q)
            S_RD_HI1, S_RD_HI2: begin
                mt_rd_en = 1'b1;
                mt_addr  = {reg_q, 1'b1};
            end
            S_RD_LO: begin
                mt_rd_en = 1'b1;
                mt_addr  = {reg_q, 1'b0};
            end
            S_WR_GUARD: begin
                // Max lo for mtimecmp, zero lo for mtime: either way the
                // half-written value cannot cross the compare point.
                mt_wr_en     = 1'b1;
                mt_addr      = {reg_q, 1'b0};
                mt_wr_data   = reg_q ? 32'hFFFF_FFFF : 32'h0000_0000;
                mt_wr_strobe = 4'hF;
            end
            S_WR_HI: begin
                mt_wr_en     = 1'b1;
                mt_addr      = {reg_q, 1'b1};
                mt_wr_data   = wdata_q[63:32];
                mt_wr_strobe = 4'hF;
            end
            S_WR_LO: begin
                mt_wr_en     = 1'b1;
                mt_addr      = {reg_q, 1'b0};
                mt_wr_data   = wdata_q[31:0];
                mt_wr_strobe = 4'hF;
            end
            default: ;
        endcase
    end

    // Sequencer next-state: accept, hi-lo-hi read with retry, 3-step write.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        retry_d  = retry_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    owner_d  = gnt_idx;
                    we_d     = req_we[gnt_idx];
                    reg_d    = req_reg[gnt_idx];
                    wdata_d  = gnt_wdata;
                    retry_d  = '0;
                    rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IW'(1);
                    state_d  = req_we[gnt_idx] ? S_WR_GUARD : S_RD_HI1;
                end
            end
            S_RD_HI1: begin
                hi_d    = mt_rd_data;
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
                lo_d    = mt_rd_data;
                state_d = S_RD_HI2;
            end
            S_RD_HI2: begin
                if (mt_rd_data == hi_q) begin
                    rdata_d = {hi_q, lo_q};
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (int'(retry_q) < MAX_RETRY) begin
                    retry_d = retry_q + RW'(1);
                    hi_d    = mt_rd_data;
                    state_d = S_RD_LO;
                end else begin
                    rdata_d = {hi_q, lo_q};
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WR_GUARD: state_d = S_WR_HI;
            S_WR_HI:    state_d = S_WR_LO;
            S_WR_LO: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            we_q     <= 1'b0;
            reg_q    <= 1'b0;
            wdata_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            retry_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            retry_q  <= retry_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/mtime_access_ctrl.md
Name: mtime_access_ctrl

Overview:
- Arbitrates 64-bit read/write requests from NUM_REQ requesters (core LSU, debug module) onto the single 32-bit register port of the machine timer block (mtime/mtimecmp).
- Sequences each 64-bit access as 32-bit accesses that are safe against carry and spurious interrupts:
  - Reads use hi-lo-hi with retry.
  - Writes use guard-lo, hi, lo.
- Sits between the requesters and the timer register port, replacing the direct DBus connection.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- MAX_RETRY, 3, maximum hi-lo-hi re-read attempts before the response carries an error.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_reg  input  NUM_REQ  0 = mtime, 1 = mtimecmp
- req_wdata  input  NUM_REQ*64  write data, requester i at [64i+63:64i]
- resp_valid  output  NUM_REQ  one-cycle completion pulse to the owning requester
- resp_rdata  output  64  read result; shared; valid with resp_valid
- resp_err  output  1  read retries exhausted; valid with resp_valid
- mt_rd_en  output  1  timer port read enable
- mt_wr_en  output  1  timer port write enable
- mt_addr  output  2  timer word address: {reg, hi_word}
- mt_wr_data  output  32  timer write data
- mt_wr_strobe  output  4  timer byte strobes
- mt_rd_data  input  32  timer read data; combinational, same cycle as mt_rd_en

Behaviour:
- Reset (rst=1 at posedge):
  - FSM → IDLE; rr_ptr=0; retry_cnt=0; captured data cleared.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - mt_rd_en=0, mt_wr_en=0, mt_addr=0, mt_wr_data=0, mt_wr_strobe=0.
  - A reset mid-sequence aborts the sequence with no response. A partially written timer value is left as-is.
- Arbitration (IDLE only):
  - Round-robin starting at rr_ptr. grant = first i in rr_ptr, rr_ptr+1, … (mod NUM_REQ) with req_valid[i]=1.
  - req_ready[grant]=1 combinationally in IDLE; all req_ready=0 outside IDLE.
  - Handshake completes when valid&ready. On accept: latch we, reg, wdata, owner=grant; rr_ptr ← grant+1 mod NUM_REQ; retry_cnt ← 0.
  - With no valid requests, stay in IDLE; rr_ptr unchanged.
- mt_* outputs: combinational from state and latched request; mt_wr_strobe=4'hF on every write; all zero in IDLE and RESP.
- Read states:
  - RD_HI1: rd addr {reg,1}; hi_a ← mt_rd_data.
  - RD_LO: rd addr {reg,0}; lo ← mt_rd_data.
  - RD_HI2: rd addr {reg,1}.
    - If mt_rd_data==hi_a → RESP with data {hi_a, lo}, err=0.
    - Else if retry_cnt<MAX_RETRY: retry_cnt++, hi_a ← mt_rd_data, → RD_LO.
    - Else → RESP with data {hi_a, lo}, err=1.
- Write states:
  - WR_GUARD: wr addr {reg,0}; data 32'hFFFF_FFFF if reg=1, else 32'h0000_0000.
  - WR_HI: wr addr {reg,1}; data wdata[63:32].
  - WR_LO: wr addr {reg,0}; data wdata[31:0].
  - After WR_LO → RESP. Write responses report resp_rdata=0, err=0.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle; resp_rdata and resp_err are driven that cycle and hold until the next RESP.
  - Then → IDLE. A new accept is possible in the cycle after RESP.
- Latency from the accept cycle T: response at T+4 for writes and for clean reads; each read retry adds 2 cycles.
- Only one transaction is in flight. A requester may hold req_valid through its own response; it is re-arbitrated fairly.
- Increments by the timer during a write sequence are overwritten by the following write (timer-side rule). The guard write makes the intermediate value safe.

Test Plan:
- Two requesters assert reads of mtime in the same cycle from reset → req0 is granted first, req1 is granted at the cycle after req0's RESP; each resp_valid pulses once on its own index; latency is 4 cycles each.
- Timer model with mtime=0x0000_0001_FFFF_FFFF, incrementing during RD_LO → hi mismatch; one retry; resp_rdata=0x0000_0002_0000_0000 (or the incremented lo); resp_err=0; latency 6.
- Read with mt_rd_data forced so hi differs on every RD_HI2 → MAX_RETRY=3 retries; resp_err=1; response at T+10.
- Write mtimecmp=0x0000_0005_0000_0010 with mtime=0x0000_0004_FFFF_FFFF → port sees writes (addr2, FFFF_FFFF), (addr3, 0000_0005), (addr2, 0000_0010); interrupt never asserts during the sequence.
- Write mtime=0x1234_5678_9ABC_DEF0 → writes (0, 0000_0000), (1, 1234_5678), (0, 9ABC_DEF0); a subsequent read returns that value (±ticks); mt_wr_strobe=F throughout.
- rst pulsed during WR_HI → all outputs 0 the next cycle; no resp_valid; rr_ptr=0 (req0 wins the next tie).
